// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared FSM encoding and default geometry for mem_responder
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE  = 32'h8000_0000;
  localparam int          DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response handshake bundle between initiator and responder
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - synchronous byte-masked 32-bit single-port word RAM, no reset
module mem_array #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // rdata only moves on an enabled read, so it stays put while a response waits
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory responder with byte masks and range checking
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH   = DEFAULT_DEPTH,
  parameter logic [31:0] BASE    = DEFAULT_BASE,
  parameter int          LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t state, state_n;
  logic [3:0]    cnt;
  logic          load, access;
  logic          lat_wen, lat_err;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wmask;
  logic [29:0]   word_off;
  logic [31:0]   ram_rdata;

  // Addresses below BASE wrap to a huge offset and fall out of range naturally
  assign word_off = 30'((bus.req_addr - BASE) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = WAIT;
        load    = 1'b1;
      end
      WAIT: if (cnt == 4'd0) begin
        state_n = RESP;
        access  = 1'b1;
      end
      RESP: if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_wen   <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (load) begin
      cnt       <= CNT_INIT;
      lat_wen   <= bus.req_wen;
      lat_err   <= (word_off >= DEPTH_W);
      lat_idx   <= word_off[AW-1:0];
      lat_wdata <= bus.req_wdata;
      lat_wmask <= bus.req_wmask;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  mem_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .en    (access && !lat_err),
    .we    (lat_wen),
    .addr  (lat_idx),
    .wdata (lat_wdata),
    .wmask (lat_wmask),
    .rdata (ram_rdata)
  );

  // req_ready is gated by rst so it drops the instant reset asserts
  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = (state == RESP) && lat_err;
  assign bus.resp_rdata = ((state == RESP) && !lat_wen && !lat_err) ? ram_rdata : 32'h0;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: storage size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE, default 32'h8000_0000: byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to resp_valid; legal range is 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-008 SHALL have port req_wen, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address; bits [1:0] are ignored (word-aligned access).
REQ-010 SHALL have port req_wdata, input, 32 bits: write data, already lane-positioned, little-endian.
REQ-011 SHALL have port req_wmask, input, 4 bits: byte-lane enables; bit i covers wdata[8i+7:8i].
REQ-012 SHALL have port resp_valid, output, 1 bit: response available.
REQ-013 SHALL have port resp_ready, input, 1 bit: initiator accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32 bits: full aligned word for reads; 0 for writes and errors.
REQ-015 SHALL have port resp_err, output, 1 bit: address outside [BASE, BASE+4*DEPTH).

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 at a clock edge.
REQ-018 SHALL latch req_wen, the word index, req_wdata and req_wmask on acceptance, load a counter with LATENCY-1, and enter WAIT.
REQ-019 SHALL decrement the counter each cycle in WAIT; when the counter is 0, it SHALL perform the access and enter RESP. With LATENCY=1, resp_valid asserts in the cycle after acceptance.
REQ-020 SHALL, for a read, register the stored word into resp_rdata when entering RESP.
REQ-021 SHALL, for a write, update only the masked bytes when entering RESP; if req_wmask is 0, no bytes change.
REQ-022 SHALL, for an out-of-range address, set resp_err=1 and resp_rdata=0, and leave storage unmodified.
REQ-023 SHALL hold resp_valid=1 and keep resp_rdata and resp_err stable in RESP until resp_ready=1 at a clock edge, then return to IDLE.
REQ-024 SHALL NOT accept a new request in the cycle the response completes; the next acceptance is no earlier than the following edge, so throughput is at most one request per LATENCY+2 cycles.
REQ-025 SHALL leave req_ready=1 when req_valid=0 in IDLE and SHALL change no state.
REQ-026 SHALL NOT change outputs based on changes to req_* inputs outside the acceptance edge.
REQ-027 SHALL compute the word index as (req_addr-BASE)>>2 using 32-bit unsigned arithmetic; any address below BASE SHALL wrap to a large value and be flagged as an error.

Reset
REQ-028 SHALL, while rst=1, force the state to IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0 and counter=0, regardless of clk.
REQ-029 SHALL raise req_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL abort any in-flight request when reset occurs mid-operation: no response is produced, and a write not yet committed SHALL NOT be committed.
REQ-031 SHALL NOT clear storage contents on reset.

Structure
REQ-032 SHALL place the FSM state encoding (2 bits: IDLE=0, WAIT=1, RESP=2) and the default BASE/DEPTH constants in the shared package.
REQ-033 SHALL instantiate one sub-module, mem_array: a synchronous, byte-masked, 32-bit-wide single-port word RAM with no reset.
REQ-034 SHALL contain no DPI calls; the block is fully synthesizable.

Verification
REQ-035 Write then read, LATENCY=2: write addr 8000_0010, wdata DEADBEEF, mask F; then read 8000_0010 -> resp_rdata=DEADBEEF, resp_err=0, resp_valid asserts 2 cycles after each acceptance.
REQ-036 Byte-lane masks: write 8000_0020 = 11223344 with mask F; write 8000_0022 = AB000000 with mask 8 (addr bits [1:0] ignored); read 8000_0020 -> AB223344.
REQ-037 Backpressure: hold resp_ready=0 for 5 cycles during a read -> resp_valid and resp_rdata remain stable, req_ready=0 throughout; 1 cycle after resp_ready rises, req_ready=1.
REQ-038 Out-of-range: read 7FFF_FFFC and read BASE+4*DEPTH -> resp_err=1, resp_rdata=0; a write to 9000_0000 leaves all words unchanged.
REQ-039 Reset mid-write: accept a write of CAFEF00D to 8000_0040, assert rst during WAIT -> outputs immediately 0, no response; after reset, a read of 8000_0040 returns the old value.
REQ-040 LATENCY=1 with back-to-back requests and resp_ready tied to 1 -> each response arrives in the cycle after acceptance, and requests are accepted every 3 cycles.
